// File: rtl/merge_pkg.sv
// Shared definitions for the merge tree: record width default and the
// terminator record that closes every sorted sequence.
package merge_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [DATA_W_DEF-1:0] REC_ZERO = '0;

    function automatic logic is_term(input logic [DATA_W_DEF-1:0] rec);
        return rec == REC_ZERO;
    endfunction

endpackage

// File: rtl/merge_fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port, so the head record falls through without latency.
module merge_fifo_ram
    import merge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are never reset; validity is tracked by the FIFO count.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/merge_in_fifo.sv
// First-word-fall-through input buffer ahead of the merge CONTROL stage.
// Produces empty / head-is-terminator flags and almost-full back-pressure.
module merge_in_fifo
    import merge_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head,
    output logic                       o_empty,
    output logic                       o_head_zero,
    output logic                       o_r_head_zero,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              r_head_zero;
    logic [DATA_W-1:0] rd_data;
    logic              rd_is_term;
    logic              empty;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    merge_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (push_ok),
        .i_waddr (wr_ptr),
        .i_wdata (i_data),
        .i_raddr (rd_ptr),
        .o_rdata (rd_data)
    );

    generate
        if (DATA_W == DATA_W_DEF) begin : g_term_pkg
            assign rd_is_term = is_term(rd_data);
        end else begin : g_term_local
            assign rd_is_term = ~|rd_data;
        end
    endgenerate

    // Flags decode only registered state so CONTROL sees no push/pop loop.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign pop_ok  = i_pop & ~empty;
    assign push_ok = i_push & (~full | pop_ok);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            r_head_zero <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr      <= rd_ptr + 1'b1;
                r_head_zero <= rd_is_term;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (i_push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign o_head        = empty ? '0 : rd_data;
    assign o_empty       = empty;
    assign o_head_zero   = ~empty & rd_is_term;
    assign o_r_head_zero = r_head_zero;
    assign o_full        = full;
    assign o_almost_full = (32'(DEPTH) - 32'(count)) <= 32'(AF_MARGIN);
    assign o_count       = count;
    assign o_overflow    = overflow;

endmodule

// File: tb/tb_merge_in_fifo.sv
// Directed, table-driven bench for merge_in_fifo (DEPTH=8, AF_MARGIN=2),
// plus hand-written fill/overflow and wrap-around sequences.
module tb_merge_in_fifo;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] data = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] head;
    logic          empty, head_zero, r_head_zero, full, almost_full, overflow;
    logic [3:0]    count;

    int checks = 0;
    int failures = 0;

    merge_in_fifo #(.DATA_W(DW), .DEPTH(8), .AF_MARGIN(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_push        (push),
        .i_data        (data),
        .i_pop         (pop),
        .o_head        (head),
        .o_empty       (empty),
        .o_head_zero   (head_zero),
        .o_r_head_zero (r_head_zero),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_count       (count),
        .o_overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst_n;
        logic          push;
        logic [DW-1:0] data;
        logic          pop;
        logic [3:0]    cnt;
        logic          e;
        logic [DW-1:0] head;
        logic          full;
        logic          af;
        logic          ovf;
        logic          hz;
        logic          rhz;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic e, input logic [DW-1:0] h,
                             input logic f, input logic af, input logic ovf, input logic hz,
                             input logic rhz);
        chk({tag, ".count"}, DW'(count), DW'(c));
        chk({tag, ".empty"}, DW'(empty), DW'(e));
        chk({tag, ".head"}, head, h);
        chk({tag, ".full"}, DW'(full), DW'(f));
        chk({tag, ".almost_full"}, DW'(almost_full), DW'(af));
        chk({tag, ".overflow"}, DW'(overflow), DW'(ovf));
        chk({tag, ".head_zero"}, DW'(head_zero), DW'(hz));
        chk({tag, ".r_head_zero"}, DW'(r_head_zero), DW'(rhz));
    endtask

    // Drive away from the active edge, sample just after it.
    task automatic step(input logic r, input logic pu, input logic [DW-1:0] d, input logic po);
        @(negedge clk);
        rst_n = r;
        push  = pu;
        data  = d;
        pop   = po;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic pu, input logic [DW-1:0] d, input logic po,
                                input logic [3:0] c, input logic e, input logic [DW-1:0] h,
                                input logic hz, input logic rhz);
        vec_t v;
        v.rst_n = r; v.push = pu; v.data = d; v.pop = po;
        v.cnt = c; v.e = e; v.head = h;
        v.full = 1'b0; v.af = 1'b0; v.ovf = 1'b0;
        v.hz = hz; v.rhz = rhz;
        return v;
    endfunction

    logic [DW-1:0] model [$];
    logic [DW-1:0] nxt;

    initial begin
        //          rst push data   pop cnt empty head   hz rhz
        vecs[0]  = mk(0, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0);
        vecs[1]  = mk(0, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0);
        vecs[2]  = mk(1, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0);
        vecs[3]  = mk(1, 1, 32'h11, 0, 1, 0, 32'h11, 0, 0);
        vecs[4]  = mk(1, 1, 32'h22, 0, 2, 0, 32'h11, 0, 0);
        vecs[5]  = mk(1, 1, 32'h33, 0, 3, 0, 32'h11, 0, 0);
        vecs[6]  = mk(1, 0, 32'h0,  1, 2, 0, 32'h22, 0, 0);
        vecs[7]  = mk(1, 0, 32'h0,  1, 1, 0, 32'h33, 0, 0);
        vecs[8]  = mk(1, 0, 32'h0,  1, 0, 1, 32'h0,  0, 0);
        vecs[9]  = mk(1, 0, 32'h0,  1, 0, 1, 32'h0,  0, 0);
        vecs[10] = mk(1, 1, 32'h05, 0, 1, 0, 32'h05, 0, 0);
        vecs[11] = mk(1, 1, 32'h00, 0, 2, 0, 32'h05, 0, 0);
        vecs[12] = mk(1, 0, 32'h0,  1, 1, 0, 32'h00, 1, 0);
        vecs[13] = mk(1, 0, 32'h0,  1, 0, 1, 32'h0,  0, 1);
        vecs[14] = mk(1, 1, 32'h77, 1, 1, 0, 32'h77, 0, 1);
        vecs[15] = mk(1, 0, 32'h0,  1, 0, 1, 32'h0,  0, 0);
        vecs[16] = mk(1, 1, 32'hA1, 0, 1, 0, 32'hA1, 0, 0);
        vecs[17] = mk(1, 1, 32'hA2, 0, 2, 0, 32'hA1, 0, 0);
        vecs[18] = mk(1, 1, 32'hA3, 0, 3, 0, 32'hA1, 0, 0);
        vecs[19] = mk(1, 1, 32'hA4, 0, 4, 0, 32'hA1, 0, 0);
        vecs[20] = mk(1, 1, 32'hA5, 0, 5, 0, 32'hA1, 0, 0);
        vecs[21] = mk(0, 1, 32'hA6, 0, 0, 1, 32'h0,  0, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst_n, vecs[i].push, vecs[i].data, vecs[i].pop);
            check_all($sformatf("v%0d", i), int'(vecs[i].cnt), vecs[i].e, vecs[i].head,
                      vecs[i].full, vecs[i].af, vecs[i].ovf, vecs[i].hz, vecs[i].rhz);
        end

        // Fill to DEPTH, then overflow and push+pop while full.
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'h100 + DW'(i), 0);
            check_all($sformatf("fill%0d", i), i + 1, 0, 32'h100, (i + 1) == 8, (i + 1) >= 6, 0, 0, 0);
        end
        step(1, 1, 32'h1FF, 0);
        check_all("ovf_push", 8, 0, 32'h100, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("ovf_sticky", DW'(overflow), 1);
        step(1, 1, 32'h200, 1);
        check_all("full_pushpop", 8, 0, 32'h101, 1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            nxt = (i < 7) ? 32'h101 + DW'(i) : 32'h200;
            chk($sformatf("drain%0d.head", i), head, nxt);
            step(1, 0, 0, 1);
            chk($sformatf("drain%0d.count", i), DW'(count), DW'(7 - i));
        end
        chk("drain.empty", DW'(empty), 1);

        // Wrap-around: steady push+pop at count=3, scoreboard queue.
        step(0, 0, 0, 0);
        model.delete();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h300 + DW'(i), 0);
            model.push_back(32'h300 + DW'(i));
        end
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wrap%0d.head", i), head, model[0]);
            void'(model.pop_front());
            model.push_back(32'h400 + DW'(i));
            step(1, 1, 32'h400 + DW'(i), 1);
            chk($sformatf("wrap%0d.count", i), DW'(count), 3);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wdrain%0d.head", i), head, model[0]);
            void'(model.pop_front());
            step(1, 0, 0, 1);
        end
        check_all("wrap_end", 0, 1, 32'h0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/merge_in_fifo.md
Name: merge_in_fifo

Overview:
- Input buffer that sits directly upstream of the merge CONTROL stage. One instance feeds the A side of a merger and one feeds the B side.
- Buffers records arriving from the previous tree level. Presents the head record first-word-fall-through.
- Generates the per-side flags the controller consumes: empty, head-is-zero (terminator) and registered last-popped-was-zero.
- Provides almost-full back-pressure to the upstream merger.

Parameters:
- DATA_W, 32, record width in bits; the all-zero record is the sequence terminator.
- DEPTH, 8, number of entries; must be a power of two and at least 4.
- AF_MARGIN, 2, o_almost_full asserts when free slots are AF_MARGIN or fewer; covers the upstream stall latency.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_push  in  1  write request for i_data.
- i_data  in  DATA_W  record to write.
- i_pop  in  1  consume the head record; driven by CONTROL select/advance.
- o_head  out  DATA_W  current head record; valid only when o_empty=0.
- o_empty  out  1  no record present; maps to CONTROL i_a_empty / i_b_empty.
- o_head_zero  out  1  o_empty=0 and o_head==0; maps to i_a_min_zero / i_b_min_zero.
- o_r_head_zero  out  1  last popped record was a terminator; maps to i_r_a_min_zero / i_r_b_min_zero.
- o_full  out  1  count==DEPTH.
- o_almost_full  out  1  DEPTH-count <= AF_MARGIN; maps to the upstream merger's i_fifo_out_full.
- o_count  out  $clog2(DEPTH+1)  current occupancy.
- o_overflow  out  1  sticky; a push was dropped.

Behaviour:
- Reset: synchronous, sampled on the i_clk rising edge while i_rst_n=0. All outputs go to these values:
  - o_empty=1, o_count=0.
  - o_head_zero=0, o_r_head_zero=0.
  - o_full=0, o_overflow=0.
  - o_almost_full = (DEPTH <= AF_MARGIN), i.e. 0 for legal parameters.
  - o_head = 0.
- Reset mid-operation discards all contents and wins over simultaneous push/pop.
- Storage is a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits. Pointers wrap DEPTH-1 -> 0 naturally, with no extra compare.
- Occupancy is tracked by the o_count register; full and empty are derived from the count, never from pointer equality.
- Push latency: a record pushed into an empty FIFO appears on o_head with o_empty=0 in the cycle after the push edge. This is one cycle of latency and there is no combinational i_data->o_head path.
- Pop is first-word-fall-through: o_head is valid while o_empty=0. Asserting i_pop consumes the head at the edge, and the next record, if any, is on o_head the following cycle.
- Accept rules, evaluated each edge:
  - pop_ok = i_pop & ~o_empty.
  - push_ok = i_push & (~o_full | pop_ok).
  - count_next = count + push_ok - pop_ok.
- Boundary cases:
  - Pop while empty: ignored; no state change.
  - Push while full without pop: dropped, and o_overflow is set to 1 until reset.
  - Push and pop while full: both accepted; count stays DEPTH.
  - Push and pop while empty: pop ignored, push accepted, count becomes 1.
  - Push and pop with 0<count<DEPTH: both accepted, count unchanged, the new record lands at the tail.
- o_head_zero is combinational from the registered head entry and o_empty. It is 0 whenever o_empty=1.
- o_r_head_zero is a register:
  - On pop_ok it loads (head==0), i.e. it is set after a terminator is popped and cleared on the pop of a non-zero record.
  - Otherwise it holds.
- o_full, o_almost_full and o_empty are registered, or decoded from the registered count with no input dependence. They must not combinationally depend on i_push or i_pop, which prevents loops with CONTROL.
- Storage requires no reset; only pointers, count and flags are reset.

Decomposition:
- Shared package (merge_pkg) holds:
  - the record-width default DATA_W_DEF=32;
  - the terminator constant REC_ZERO = '0;
  - a function is_term(rec) returning rec==REC_ZERO, shared with CONTROL and the output stage.
- One sub-module, merge_fifo_ram: DEPTH x DATA_W register array with one write port and an asynchronous read port indexed by rd_ptr.
- Pointer, count and flag logic stay in merge_in_fifo.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 2 edges, then release -> o_empty=1, o_count=0, all other flags 0, o_head=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times:
  - o_head=0x11 one cycle after the first push;
  - pops yield 0x11, 0x22, 0x33 in order;
  - o_empty=1 after the third pop; o_count tracks 1,2,3,2,1,0.
- Fill with DEPTH=8 records:
  - o_almost_full rises at count=6, o_full at count=8;
  - a 9th push without pop -> dropped, o_overflow=1 and sticky;
  - push and pop same cycle while full -> count stays 8, and the next-to-last head order is preserved.
- Wrap-around: push and pop continuously for 20 cycles at count=3 -> pointers wrap twice and the data sequence is intact.
- Terminator handling: push 0x05, then 0x00:
  - o_head_zero=0 while head=0x05;
  - after popping 0x05, o_head_zero=1 and o_r_head_zero=0;
  - after popping 0x00, o_r_head_zero=1 and o_empty=1, so o_head_zero=0.
- Corner cases:
  - pop on empty -> no change;
  - push and pop on empty -> count=1, head valid next cycle;
  - assert i_rst_n=0 with count=5 while pushing -> next cycle count=0, o_empty=1, o_overflow=0.
